snake_row_render: RTL



---
 rtl/snake_row_render.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/snake_row_render.sv
// Snake row renderer: during hblank, scans the snake snapshot into a ping-pong
// pair of per-row head/body bitmaps, then answers per-pixel lookups from the display half.
module snake_row_render #(
    parameter int CELL     = 10,
    parameter int GRID_W   = 64,
    parameter int MAX_BODY = 32,
    parameter int MAX_LEN  = MAX_BODY + 1
) (
    input  logic                  clk_pix,
    input  logic                  reset_n,
    input  logic                  line_start,
    input  logic [8:0]            next_y,
    input  logic [MAX_LEN*10-1:0] body_bus_x,
    input  logic [MAX_LEN*9-1:0]  body_bus_y,
    input  logic [7:0]            length,
    input  logic [9:0]            pix_x,
    input  logic                  video_on,
    output logic                  head_px,
    output logic                  body_px,
    output logic                  busy,
    output logic                  overrun
);
    localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SCAN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                  r_disp_sel;
    logic [GRID_W-1:0]     r_head_buf [2];
    logic [GRID_W-1:0]     r_body_buf [2];
    logic [MAX_LEN*10-1:0] r_snap_x;
    logic [MAX_LEN*9-1:0]  r_snap_y;
    logic [8:0]            r_ny;
    logic [LW-1:0]         r_eff_len;
    logic [LW-1:0]         r_idx;
    logic                  r_head_px;
    logic                  r_body_px;
    logic                  r_overrun;

    logic [9:0]            w_seg_x [MAX_LEN];
    logic [8:0]            w_seg_y [MAX_LEN];
    logic [9:0]            w_sx;
    logic [9:0]            w_sy10;
    logic [9:0]            w_ny10;
    logic [9:0]            w_col;
    logic                  w_col_ok;
    logic                  w_hit;
    logic                  w_last;
    logic                  w_fill;
    logic [LW-1:0]         w_len_clip;
    logic [9:0]            w_pc;
    logic                  w_pc_ok;

    // Segment 0 (head) sits in the most significant slice of each bus.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_unpack
            assign w_seg_x[gi] = r_snap_x[(MAX_LEN-1-gi)*10 +: 10];
            assign w_seg_y[gi] = r_snap_y[(MAX_LEN-1-gi)*9 +: 9];
        end
    endgenerate

    assign w_len_clip = (length > 8'(MAX_LEN)) ? LW'(MAX_LEN) : length[LW-1:0];
    assign w_fill     = ~r_disp_sel;

    assign w_sx     = w_seg_x[r_idx[IW-1:0]];
    assign w_sy10   = {1'b0, w_seg_y[r_idx[IW-1:0]]};
    assign w_ny10   = {1'b0, r_ny};
    // Widened to 10 bits so a segment near the bottom edge does not wrap its extent.
    assign w_hit    = (w_ny10 >= w_sy10) && (w_ny10 < (w_sy10 + 10'(CELL)));
    assign w_col    = w_sx / 10'(CELL);
    assign w_col_ok = (w_col < 10'(GRID_W));
    assign w_last   = (r_idx == (r_eff_len - LW'(1)));

    assign w_pc    = pix_x / 10'(CELL);
    assign w_pc_ok = (w_pc < 10'(GRID_W));

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (line_start) w_state_next = CLEAR;
            end
            CLEAR: begin
                if (line_start)               w_state_next = CLEAR;
                else if (r_eff_len == '0)     w_state_next = IDLE;
                else                          w_state_next = SCAN;
            end
            SCAN: begin
                if (line_start)  w_state_next = CLEAR;
                else if (w_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign busy = (r_state == CLEAR) || (r_state == SCAN);

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_disp_sel    <= 1'b0;
            r_head_buf[0] <= '0;
            r_head_buf[1] <= '0;
            r_body_buf[0] <= '0;
            r_body_buf[1] <= '0;
            r_snap_x      <= '0;
            r_snap_y      <= '0;
            r_ny          <= '0;
            r_eff_len     <= '0;
            r_idx         <= '0;
            r_head_px     <= 1'b0;
            r_body_px     <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            // Lookup reads the display half selected before any toggle this cycle.
            r_head_px <= video_on && w_pc_ok && r_head_buf[r_disp_sel][w_pc[CW-1:0]];
            r_body_px <= video_on && w_pc_ok && r_body_buf[r_disp_sel][w_pc[CW-1:0]];
            r_overrun <= line_start && busy;

            if (line_start) begin
                r_disp_sel <= ~r_disp_sel;
                r_ny       <= next_y;
                r_snap_x   <= body_bus_x;
                r_snap_y   <= body_bus_y;
                r_eff_len  <= w_len_clip;
                r_idx      <= '0;
            end else if (r_state == CLEAR) begin
                r_head_buf[w_fill] <= '0;
                r_body_buf[w_fill] <= '0;
                r_idx              <= '0;
            end else if (r_state == SCAN) begin
                if (w_hit && w_col_ok) begin
                    if (r_idx == '0) r_head_buf[w_fill][w_col[CW-1:0]] <= 1'b1;
                    else             r_body_buf[w_fill][w_col[CW-1:0]] <= 1'b1;
                end
                r_idx <= r_idx + LW'(1);
            end
        end
    end

    assign head_px = r_head_px;
    assign body_px = r_body_px;
    assign overrun = r_overrun;

endmodule
